// File: rtl/pri_encoder_n_arb.sv
// Registered priority encoder with a one-entry valid/ready output stage.
// Define PRI_ENC_RR_EN for round-robin priority; the default build uses fixed priority (MSB wins).
module pri_encoder_n_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_vld,
  output logic         req_rdy,
  output logic [W-1:0] out,
  output logic         dis,
  output logic         out_vld,
  input  logic         out_rdy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] out_reg, out_next;
  logic         dis_reg, dis_next;
  logic [W-1:0] winner;
  logic         xfer_in, xfer_out;

  function automatic logic [W-1:0] msb_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

`ifdef PRI_ENC_RR_EN
  logic [W-1:0] ptr_reg, ptr_next;
  logic [N-1:0] low_mask;
  logic [N-1:0] low_req;
  genvar gi;

  // Indices below ptr are searched first (ptr-1 downward); the rest follow from N-1.
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign low_mask[gi] = (32'(gi) < 32'(ptr_reg));
    end
  endgenerate

  assign low_req  = req & low_mask;
  assign winner   = (|low_req) ? msb_index(low_req) : msb_index(req);
  assign ptr_next = (xfer_in && (|req)) ? winner : ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  assign winner = msb_index(req);
`endif

  assign out_vld  = (state_reg == FULL);
  assign req_rdy  = ~out_vld | out_rdy;
  assign xfer_in  = req_vld & req_rdy;
  assign xfer_out = out_vld & out_rdy;
  assign out      = out_reg;
  assign dis      = dis_reg;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    dis_next   = dis_reg;
    case (state_reg)
      EMPTY:   if (xfer_in) state_next = FULL;
      FULL:    if (xfer_out && !xfer_in) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    // A new capture overrides the drain, so a full stage can refill in the same cycle.
    if (xfer_in) begin
      dis_next = ~(|req);
      out_next = (|req) ? winner : '0;
    end else if (xfer_out) begin
      dis_next = 1'b1;
      out_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      out_reg   <= '0;
      dis_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      dis_reg   <= dis_next;
    end
  end

endmodule

// File: tb/tb_pri_encoder_n_arb.sv
// Self-checking bench for pri_encoder_n_arb (N=8); compares against a behavioural model.
// Compile with PRI_ENC_RR_EN defined to exercise the round-robin build.
module tb_pri_encoder_n_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic [W-1:0] out;
  logic         dis;
  logic         out_vld;
  logic         out_rdy = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  // Model state
  bit m_vld = 0;
  int m_out = 0;
  bit m_dis = 1;
  int m_ptr = 0;

  pri_encoder_n_arb #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .out     (out),
    .dis     (dis),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  // Winner as the search order is described: start one below ptr, walk down with wrap.
  function automatic int ref_winner(input logic [N-1:0] r, input int p);
`ifdef PRI_ENC_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p - k + N) % N;
      if (r[idx]) return idx;
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_vld = 0;
    m_out = 0;
    m_dis = 1;
    m_ptr = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_vld"}, longint'(out_vld), longint'(m_vld));
    chk({tag, ".out"},     longint'(out),     longint'(m_out));
    chk({tag, ".dis"},     longint'(dis),     longint'(m_dis));
  endtask

  // One clock: drive at posedge+1, check req_rdy, step the model across the edge, check outputs.
  task automatic cycle(input string tag, input logic [N-1:0] r, input bit v, input bit ordy);
    bit in_x, out_x;
    req     = r;
    req_vld = v;
    out_rdy = ordy;
    #1;
    chk({tag, ".req_rdy"}, longint'(req_rdy), longint'(!m_vld || ordy));
    in_x  = v && (!m_vld || ordy);
    out_x = m_vld && ordy;
    if (out_x) $display("out xfer: out=%0d dis=%0d", m_out, m_dis);
    @(posedge clk);
    #1;
    if (in_x) begin
      m_vld = 1;
      if (r == '0) begin
        m_out = 0;
        m_dis = 1;
      end else begin
        m_out = ref_winner(r, m_ptr);
        m_dis = 0;
        m_ptr = m_out;
      end
    end else if (out_x) begin
      m_vld = 0;
      m_out = 0;
      m_dis = 1;
    end
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    req_vld = 1'b0;
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_outputs("reset");

    // All-zero request is a reportable result
    cycle("zero_req", 8'h00, 1, 1);
    chk("zero_req.dis_const", longint'(dis), 1);

    // Back-to-back sweep with the consumer always ready
    do_reset();
    for (int i = 1; i < 256; i++) cycle("sweep", 8'(i), 1, 1);
    cycle("sweep_drain", 8'h00, 0, 1);

    // Backpressure hold
    do_reset();
    cycle("hold_acc", 8'h12, 1, 1);
    chk("hold_acc.out_const", longint'(out), 4);
    for (int i = 0; i < 5; i++) begin
      cycle("hold", 8'hFF, 1, 0);
      chk("hold.out_const", longint'(out), 4);
    end
    cycle("hold_release", 8'hFF, 1, 1);
`ifndef PRI_ENC_RR_EN
    chk("hold_release.out_const", longint'(out), 7);
`endif

`ifdef PRI_ENC_RR_EN
    // Round-robin rotation on a saturated request
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle("rr_ff", 8'hFF, 1, 1);
      chk("rr_ff.seq", longint'(out), longint'((7 - i + 8) % 8));
    end
    do_reset();
    cycle("rr_ptr5", 8'h20, 1, 1);
    cycle("rr_90a", 8'h90, 1, 1);
    chk("rr_90a.out_const", longint'(out), 4);
    cycle("rr_90b", 8'h90, 1, 1);
    chk("rr_90b.out_const", longint'(out), 7);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle("rand", r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset while holding a result
    do_reset();
    cycle("arst_fill", 8'h5A, 1, 0);
    cycle("arst_hold", 8'h01, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("arst_immediate");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("arst_after", 8'hFF, 1, 1);
    chk("arst_after.out_const", longint'(out), 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pri_encoder_n_arb.md
PRI_ENCODER_N_ARB -- requirements
Module: pri_encoder_n_arb

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal 2..64.
REQ-002 Parameter W, default 3: output index width; SHALL equal ceil(log2(N)).
REQ-003 Port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port req  input  N  request vector; bit N-1 is highest fixed priority.
REQ-006 Port req_vld  input  1  req is valid this cycle.
REQ-007 Port req_rdy  output  1  block can accept req this cycle.
REQ-008 Port out  output  W  encoded index of the winning request.
REQ-009 Port dis  output  1  captured vector was all-zero; no winner.
REQ-010 Port out_vld  output  1  out/dis hold a result.
REQ-011 Port out_rdy  input  1  consumer takes the result this cycle.

Function
REQ-012 Transfer in SHALL occur on a clk edge with req_vld=1 and req_rdy=1; transfer out SHALL occur on a clk edge with out_vld=1 and out_rdy=1.
REQ-013 Two-state FSM: EMPTY (out_vld=0) and FULL (out_vld=1).
REQ-014 EMPTY->FULL on transfer in.
REQ-015 FULL->EMPTY on transfer out without a simultaneous transfer in.
REQ-016 FULL->FULL on simultaneous transfer out and transfer in; the new result SHALL replace the old one in that cycle, giving one result per cycle.
REQ-017 req_rdy SHALL equal (!out_vld | out_rdy), combinationally.
REQ-018 Latency: out/dis/out_vld SHALL be registered and valid on the first edge after transfer in (1 cycle).
REQ-019 While FULL and out_rdy=0, out and dis SHALL stay stable regardless of req and req_vld.
REQ-020 Fixed priority: out = index of the highest set bit of the captured req; dis=0.
REQ-021 All-zero req: out SHALL be 0 and dis SHALL be 1; out_vld still asserts, so an empty request is a reportable result.
REQ-022 req_vld=1 while req_rdy=0 SHALL have no effect; the producer must hold.
REQ-023 When out_vld=0, out SHALL be 0 and dis SHALL be 1.

Reset
REQ-024 rst_n low SHALL immediately force: FSM=EMPTY, out_vld=0, out=0, dis=1, rotation pointer=0.
REQ-025 Reset asserted mid-handshake SHALL discard any held result; the first accept after release SHALL use the reset-state priority.
REQ-026 Release SHALL be sampled synchronously; the first transfer in can occur on the first edge with rst_n=1.

Configuration
REQ-027 Macro PRI_ENC_RR_EN defined: round-robin priority.
- Register ptr (W bits).
- Search order: index (ptr-1) mod N, descending with wrap.
- On a transfer in with nonzero req and winner g, ptr becomes g.
- With ptr=0, the search starts at N-1, identical to fixed priority.
- All-zero req leaves ptr unchanged.
REQ-028 Macro PRI_ENC_RR_EN undefined: fixed priority per REQ-020, no ptr register, and no other behavioural difference.

Verification (N=8, W=3)
REQ-029 Reset, then req=8'b0000_0000 accepted -> next cycle out_vld=1, dis=1, out=0.
REQ-030 Sweep req=1..255 with out_rdy=1 -> each result available 1 cycle after accept, out = index of MSB set, dis=0, one result per cycle.
REQ-031 Accept req=8'h12, then hold out_rdy=0 for 5 cycles while driving req=8'hFF and req_vld=1 -> req_rdy=0, out stays 4, dis stays 0; on out_rdy=1 the next result is out=7.
REQ-032 PRI_ENC_RR_EN defined, req=8'hFF accepted 9 times back-to-back -> out sequence 7,6,5,4,3,2,1,0,7.
REQ-033 PRI_ENC_RR_EN defined, ptr=5 (after a grant of 5), req=8'b1001_0000 -> out=4; next req=8'b1001_0000 -> out=7.
REQ-034 rst_n pulsed low while FULL with out_rdy=0 -> out_vld=0, out=0, dis=1 immediately, without waiting for an edge; after release, req=8'hFF -> out=7.
